// File: rtl/product_accumulator.sv
// Sums each group of count_p unsigned products and holds the sum on a valid/yumi port.
// Optional clamping of the sum to all-ones: define PRODUCT_ACCUMULATOR_SATURATE_EN.
module product_accumulator #(
   parameter int unsigned width_p     = 16,
   parameter int unsigned count_p     = 4,
   parameter int unsigned acc_width_p = 18
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   clear_i,
   input  logic                   v_i,
   input  logic [width_p-1:0]     data_i,
   output logic                   ready_o,
   output logic                   v_o,
   output logic [acc_width_p-1:0] data_o,
   input  logic                   yumi_i
);

   localparam int unsigned CNT_W = $clog2(count_p) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(count_p - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic [acc_width_p-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ready_q, ready_d;
   logic                   v_q, v_d;
   logic [acc_width_p-1:0] acc_next;

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
   logic [acc_width_p:0] sum;
   assign sum      = {1'b0, acc_q} + (acc_width_p+1)'(data_i);
   assign acc_next = sum[acc_width_p] ? '1 : sum[acc_width_p-1:0];
`else
   assign acc_next = acc_q + acc_width_p'(data_i);
`endif

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      if (clear_i) begin
         state_d = ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ACCUM: begin
               if (v_i && ready_q) begin
                  acc_d = acc_next;
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == LAST_CNT) state_d = HOLD;
               end
            end
            HOLD: begin
               if (yumi_i) begin
                  state_d = ACCUM;
                  acc_d   = '0;
                  cnt_d   = '0;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
      // Handshake flags are registered copies of the next state, so no input reaches an output.
      ready_d = (state_d == ACCUM);
      v_d     = (state_d == HOLD);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         v_q     <= v_d;
      end
   end

   assign ready_o = ready_q;
   assign v_o     = v_q;
   assign data_o  = acc_q;

   yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_q);

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default build, a 16-bit accumulator and count_p=1.
module tb_product_accumulator;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // DUT A: defaults
   logic        a_clear = 1'b0, a_v = 1'b0, a_yumi = 1'b0;
   logic [15:0] a_data = '0;
   logic        a_ready, a_vo;
   logic [17:0] a_dout;
   // DUT B: 16-bit accumulator
   logic        b_clear = 1'b0, b_v = 1'b0, b_yumi = 1'b0;
   logic [15:0] b_data = '0;
   logic        b_ready, b_vo;
   logic [15:0] b_dout;
   // DUT C: single-product groups
   logic        c_clear = 1'b0, c_v = 1'b0, c_yumi = 1'b0;
   logic [15:0] c_data = '0;
   logic        c_ready, c_vo;
   logic [17:0] c_dout;

   product_accumulator dut_a (
      .clk_i(clk), .reset_n_i(reset_n), .clear_i(a_clear), .v_i(a_v), .data_i(a_data),
      .ready_o(a_ready), .v_o(a_vo), .data_o(a_dout), .yumi_i(a_yumi));

   product_accumulator #(.width_p(16), .count_p(4), .acc_width_p(16)) dut_b (
      .clk_i(clk), .reset_n_i(reset_n), .clear_i(b_clear), .v_i(b_v), .data_i(b_data),
      .ready_o(b_ready), .v_o(b_vo), .data_o(b_dout), .yumi_i(b_yumi));

   product_accumulator #(.width_p(16), .count_p(1), .acc_width_p(18)) dut_c (
      .clk_i(clk), .reset_n_i(reset_n), .clear_i(c_clear), .v_i(c_v), .data_i(c_data),
      .ready_o(c_ready), .v_o(c_vo), .data_o(c_dout), .yumi_i(c_yumi));

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [15:0] d);
      a_v = 1'b1; a_data = d; step(); a_v = 1'b0;
   endtask

   task automatic yumi_a();
      a_yumi = 1'b1; step(); a_yumi = 1'b0;
   endtask

   logic [15:0] sat_exp;

   initial begin
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
      sat_exp = 16'hFFFF;
`else
      sat_exp = 16'd5;
`endif
      // reset state
      step(); step();
      check("rst_ready", a_ready, 1);
      check("rst_v", a_vo, 0);
      check("rst_data", a_dout, 0);
      check("rst_c_ready", c_ready, 1);
      reset_n = 1'b1;
      step();

      // 1,2,3,4 back-to-back
      send_a(16'd1); send_a(16'd2); send_a(16'd3);
      check("sum10_not_yet", a_vo, 0);
      send_a(16'd4);
      check("sum10_v", a_vo, 1);
      check("sum10_data", a_dout, 10);
      check("sum10_ready", a_ready, 0);

      // backpressure: input traffic ignored in HOLD
      a_v = 1'b1; a_data = 16'd7;
      for (int i = 0; i < 5; i++) step();
      a_v = 1'b0;
      check("hold_data", a_dout, 10);
      check("hold_v", a_vo, 1);
      yumi_a();
      check("yumi_ready", a_ready, 1);
      check("yumi_v", a_vo, 0);
      check("yumi_cleared", a_dout, 0);
      for (int i = 0; i < 3; i++) send_a(16'd7);
      check("sum28_not_yet", a_vo, 0);
      send_a(16'd7);
      check("sum28_data", a_dout, 28);
      yumi_a();

      // maximum products
      for (int i = 0; i < 4; i++) send_a(16'hFE01);
      check("max_v", a_vo, 1);
      check("max_data", a_dout, 260100);
      yumi_a();

      // clear drops the concurrent input
      send_a(16'd9); send_a(16'd9);
      a_clear = 1'b1; a_v = 1'b1; a_data = 16'd100;
      step();
      a_clear = 1'b0; a_v = 1'b0;
      check("clr_data", a_dout, 0);
      check("clr_ready", a_ready, 1);
      for (int i = 0; i < 3; i++) send_a(16'd1);
      check("clr_sum4_not_yet", a_vo, 0);
      send_a(16'd1);
      check("clr_sum4_data", a_dout, 4);
      a_clear = 1'b1; a_yumi = 1'b1;
      step();
      a_clear = 1'b0; a_yumi = 1'b0;
      check("clr_hold_v", a_vo, 0);
      check("clr_hold_ready", a_ready, 1);

      // async reset in HOLD
      for (int i = 0; i < 4; i++) send_a(16'd3);
      check("pre_async_v", a_vo, 1);
      check("pre_async_data", a_dout, 12);
      #2 reset_n = 1'b0;
      #1;
      check("async_v", a_vo, 0);
      check("async_data", a_dout, 0);
      check("async_ready", a_ready, 1);
      step();
      reset_n = 1'b1;
      step();
      for (int i = 0; i < 4; i++) send_a(16'd2);
      check("post_async_data", a_dout, 8);
      check("post_async_v", a_vo, 1);
      yumi_a();

      // 16-bit accumulator overflow
      b_v = 1'b1;
      b_data = 16'h8000; step();
      b_data = 16'h8000; step();
      b_data = 16'd5;    step();
      b_data = 16'd0;    step();
      b_v = 1'b0;
      check("narrow_v", b_vo, 1);
      check("narrow_data", b_dout, sat_exp);
      b_yumi = 1'b1; step(); b_yumi = 1'b0;
      check("narrow_ready", b_ready, 1);

      // count_p=1 with gapped input
      c_v = 1'b1; c_data = 16'd5; step(); c_v = 1'b0;
      check("c1_v", c_vo, 1);
      check("c1_data", c_dout, 5);
      check("c1_ready", c_ready, 0);
      c_yumi = 1'b1; step(); c_yumi = 1'b0;
      check("c1_released", c_vo, 0);
      step();
      check("c_gap_v", c_vo, 0);
      c_v = 1'b1; c_data = 16'd6; step(); c_v = 1'b0;
      check("c2_v", c_vo, 1);
      check("c2_data", c_dout, 6);
      c_yumi = 1'b1; step(); c_yumi = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

- Sequential stage directly downstream of the 8x8 unsigned multiplier; its `data_i` is the multiplier's 16-bit product.
- Accepts a stream of unsigned products over a valid/ready handshake.
- Sums each group of `count_p` consecutive products into a wider accumulator.
- Presents each group sum on a valid/yumi output port and holds it until it is consumed.

## Interface
- `width_p`, default 16: input product width in bits.
- `count_p`, default 4: products per group; legal range 1..256.
- `acc_width_p`, default 18: accumulator and result width; must satisfy `acc_width_p >= width_p`.
- `clk_i`, input, 1: sole clock; all state updates on its rising edge.
- `reset_n_i`, input, 1: asynchronous, active-low reset.
- `clear_i`, input, 1: synchronous abort; discards the partial or held sum.
- `v_i`, input, 1: `data_i` is valid.
- `data_i`, input, `width_p`: unsigned product.
- `ready_o`, output, 1: block accepts `data_i` this cycle.
- `v_o`, output, 1: `data_o` holds a completed group sum.
- `data_o`, output, `acc_width_p`: group sum.
- `yumi_i`, input, 1: consumer takes `data_o` this cycle; legal only while `v_o=1`.

## Operation
- FSM states: ACCUM and HOLD.
- Registers:
  - `acc_r`, `acc_width_p` bits.
  - `cnt_r`, `$clog2(count_p)+1` bits.
- Reset (asynchronous assert, synchronous deassert by the surrounding system):
  - State goes to ACCUM; `acc_r=0`; `cnt_r=0`.
  - `ready_o=1`; `v_o=0`; `data_o=0`.
- ACCUM:
  - `ready_o=1`, `v_o=0`.
  - Accept occurs when `v_i & ready_o`. On accept, `acc_r <= acc_r + zero_ext(data_i)` and `cnt_r <= cnt_r+1`.
  - The accept where `cnt_r == count_p-1` loads the final sum and moves to HOLD.
- HOLD:
  - `ready_o=0`, `v_o=1`, `data_o=acc_r`; `v_i` is ignored.
  - On `yumi_i`: `acc_r <= 0`, `cnt_r <= 0`, state goes to ACCUM.
- `data_o` is driven from `acc_r` in both states. The consumer must qualify it with `v_o`.
- Arithmetic is unsigned. The sum is computed at `acc_width_p+1` bits.
- Without saturation, the result is truncated to `acc_width_p` bits, i.e. it wraps modulo 2^`acc_width_p`.
- `clear_i` has priority over every other input in both states:
  - `acc_r <= 0`, `cnt_r <= 0`, state goes to ACCUM.
  - Any input accepted or `yumi_i` asserted in the same cycle is dropped.
- `yumi_i` while `v_o=0` is a protocol violation. The block ignores it, and an assertion flags it in simulation.
- With `count_p=1`, every accept goes straight to HOLD with `data_o = zero_ext(data_i)`.

## Timing
- `ready_o` and `v_o` are pure functions of the FSM state. There is no combinational path from any input to any output.
- Latency: `v_o` rises in the cycle after the clock edge that accepted the `count_p`-th product.
- HOLD lasts at least one cycle. `ready_o` returns high in the cycle after the `yumi_i` edge.
- Peak throughput is one group per `count_p+1` cycles when the consumer asserts `yumi_i` immediately.
- Gaps in `v_i` stall accumulation without affecting state.
- Reset assertion mid-group or mid-HOLD immediately forces all outputs to their reset values; the partial sum is lost.

## Configuration
- Macro: `PRODUCT_ACCUMULATOR_SATURATE_EN`.
- Defined: if the `acc_width_p+1`-bit sum exceeds 2^`acc_width_p`-1, `acc_r` clamps to all-ones. Once saturated, `acc_r` stays at all-ones for the rest of the group.
- Not defined: the sum wraps modulo 2^`acc_width_p`.
- With the defaults, 4 × 65025 = 260100 < 262143, so the macro has no observable effect. It only matters when `acc_width_p` is reduced.

## Test plan
- Reset check: hold `reset_n_i=0` -> `ready_o=1`, `v_o=0`, `data_o=0`. Release, then send products 1, 2, 3, 4 back-to-back -> `v_o=1` with `data_o=10` one cycle after the 4th accept, and `ready_o=0`.
- Backpressure: leave `yumi_i=0` for 5 cycles and drive `v_i=1`, `data_i=7` throughout -> `data_o` stays 10 and the `v_i` traffic is not counted. Pulse `yumi_i` -> `ready_o=1` next cycle. Then send 7 ×4 -> `data_o=28`.
- Maximum values: send 0xFE01 ×4 with defaults -> `data_o=260100`. Then rebuild with `acc_width_p=16` and send 0x8000, 0x8000, 5, 0: macro undefined -> `data_o=5`; macro defined -> `data_o=0xFFFF`.
- Clear: accept 9 and 9, then assert `clear_i` together with `v_i`, `data_i=100` -> 100 is not taken. Next send 1, 1, 1, 1 -> `data_o=4`. Then assert `clear_i` and `yumi_i` together in HOLD -> `v_o=0` next cycle.
- Async reset: drive `reset_n_i` low between clock edges during HOLD -> `v_o=0` and `data_o=0` before the next edge. Then send 2 ×4 -> `data_o=8`.
- Gapped input with `count_p=1`: present `v_i` only every 3rd cycle with data 5, 6 -> two results of 5 and 6, each asserting `v_o` one cycle after its accept.
